gesture_axil_regs: RTL and testbench

AXI4-Lite slave register bank that terminates the transactions issued by the IP_Core M00_AXI master. It is the downstream stage of that master. It exposes control and threshold registers to the gesture pipeline. It also captures gesture-classifier events into readable status registers and raises an interrupt when an event is pending.

---
 rtl/gesture_axil_pkg.sv | 31 +++
 rtl/gesture_axil_regs.sv | 162 ++++++++++++++++
 tb/tb_gesture_axil_regs.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gesture_axil_pkg.sv
// Shared definitions for the gesture AXI4-Lite register bank: offsets, bit positions, FSM states.
package gesture_axil_pkg;

   localparam logic [3:0] REG_CTRL    = 4'h0;
   localparam logic [3:0] REG_THRESH  = 4'h4;
   localparam logic [3:0] REG_GESTURE = 4'h8;
   localparam logic [3:0] REG_STATUS  = 4'hC;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int ST_PEND     = 0;
   localparam int ST_OVR      = 1;
   localparam int GEST_VALID  = 31;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_DATA} rd_state_t;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/gesture_axil_regs.sv
// AXI4-Lite register bank with gesture event capture; write/read each take 2 cycles to response,
// one transaction per channel outstanding, responses held until BREADY/RREADY.
module gesture_axil_regs
   import gesture_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            gesture_valid,
   input  logic [7:0]                      gesture_code,
   output logic                            ctrl_enable,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   thresh,
   output logic                            irq
);

   wr_state_t   r_wr_state, w_wr_nxt;
   rd_state_t   r_rd_state, w_rd_nxt;

   logic [31:0] r_ctrl, r_thresh, r_rdata;
   logic [7:0]  r_code, r_count;
   logic        r_gvalid, r_pend, r_ovr, r_irq;

   logic [31:0] w_ctrl_nxt, w_thresh_nxt, w_rd_word;
   logic [7:0]  w_code_nxt, w_count_nxt;
   logic        w_gvalid_nxt, w_pend_nxt, w_ovr_nxt;
   logic        w_wr_en, w_rd_hs, w_evt;
   logic [1:0]  w_st_clr;
   logic [3:0]  w_waddr, w_raddr;
   logic        w_unused;

   assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_comb begin
      w_wr_nxt      = r_wr_state;
      S_AXI_AWREADY = 1'b0;
      S_AXI_BVALID  = 1'b0;
      case (r_wr_state)
         WR_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) w_wr_nxt = WR_ACCEPT;
         WR_ACCEPT: begin
            S_AXI_AWREADY = 1'b1;
            w_wr_nxt      = WR_RESP;
         end
         WR_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) w_wr_nxt = WR_IDLE;
         end
         default:   w_wr_nxt = WR_IDLE;
      endcase
   end

   always_comb begin
      w_rd_nxt      = r_rd_state;
      S_AXI_ARREADY = 1'b0;
      S_AXI_RVALID  = 1'b0;
      case (r_rd_state)
         RD_IDLE:   if (S_AXI_ARVALID) w_rd_nxt = RD_ACCEPT;
         RD_ACCEPT: begin
            S_AXI_ARREADY = 1'b1;
            w_rd_nxt      = RD_DATA;
         end
         RD_DATA: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) w_rd_nxt = RD_IDLE;
         end
         default:   w_rd_nxt = RD_IDLE;
      endcase
   end

   assign S_AXI_WREADY = S_AXI_AWREADY;
   assign S_AXI_BRESP  = RESP_OKAY;
   assign S_AXI_RRESP  = RESP_OKAY;
   assign S_AXI_RDATA  = r_rdata;

   assign w_wr_en = (r_wr_state == WR_ACCEPT);
   assign w_rd_hs = (r_rd_state == RD_ACCEPT);
   assign w_waddr = {S_AXI_AWADDR[3:2], 2'b00};
   assign w_raddr = {S_AXI_ARADDR[3:2], 2'b00};
   assign w_evt   = gesture_valid & r_ctrl[CTRL_EN];

   always_comb begin
      w_rd_word = 32'h0;
      case (w_raddr)
         REG_CTRL:    w_rd_word = r_ctrl;
         REG_THRESH:  w_rd_word = r_thresh;
         REG_GESTURE: w_rd_word = {r_gvalid, 15'h0, r_count, r_code};
         REG_STATUS:  w_rd_word = {30'h0, r_ovr, r_pend};
         default:     w_rd_word = 32'h0;
      endcase
   end

   // Events take priority over W1C and read-clear; overrun is judged on the pre-event pending bit.
   always_comb begin
      w_ctrl_nxt   = r_ctrl;
      w_thresh_nxt = r_thresh;
      w_st_clr     = 2'b00;
      if (w_wr_en) begin
         case (w_waddr)
            REG_CTRL:   w_ctrl_nxt   = apply_wstrb(r_ctrl, S_AXI_WDATA, S_AXI_WSTRB);
            REG_THRESH: w_thresh_nxt = apply_wstrb(r_thresh, S_AXI_WDATA, S_AXI_WSTRB);
            REG_STATUS: if (S_AXI_WSTRB[0]) w_st_clr = S_AXI_WDATA[1:0];
            default:    w_st_clr = 2'b00;
         endcase
      end
      w_code_nxt   = w_evt ? gesture_code : r_code;
      w_count_nxt  = w_evt ? r_count + 8'd1 : r_count;
      w_gvalid_nxt = w_evt | (r_gvalid & ~(w_rd_hs && (w_raddr == REG_GESTURE)));
      w_pend_nxt   = (r_pend & ~w_st_clr[ST_PEND]) | w_evt;
      w_ovr_nxt    = (r_ovr & ~w_st_clr[ST_OVR]) | (w_evt & r_pend);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_wr_state <= WR_IDLE;
         r_rd_state <= RD_IDLE;
         r_ctrl     <= 32'h0;
         r_thresh   <= 32'h0;
         r_rdata    <= 32'h0;
         r_code     <= 8'h0;
         r_count    <= 8'h0;
         r_gvalid   <= 1'b0;
         r_pend     <= 1'b0;
         r_ovr      <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_wr_state <= w_wr_nxt;
         r_rd_state <= w_rd_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_thresh   <= w_thresh_nxt;
         if (w_rd_hs) r_rdata <= w_rd_word;
         r_code     <= w_code_nxt;
         r_count    <= w_count_nxt;
         r_gvalid   <= w_gvalid_nxt;
         r_pend     <= w_pend_nxt;
         r_ovr      <= w_ovr_nxt;
         r_irq      <= w_ctrl_nxt[CTRL_IRQ_EN] & w_pend_nxt;
      end
   end

   assign ctrl_enable = r_ctrl[CTRL_EN];
   assign thresh      = r_thresh;
   assign irq         = r_irq;

endmodule

// File: tb/tb_gesture_axil_regs.sv
// Directed bench for gesture_axil_regs: inputs driven and outputs sampled on the falling clock edge.
module tb_gesture_axil_regs;

   logic        ACLK;
   logic        ARESETN;
   logic [3:0]  S_AXI_AWADDR;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        gesture_valid;
   logic [7:0]  gesture_code;
   logic        ctrl_enable;
   logic [31:0] thresh;
   logic        irq;

   int n_pass  = 0;
   int n_total = 0;

   gesture_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .gesture_valid(gesture_valid), .gesture_code(gesture_code),
      .ctrl_enable(ctrl_enable), .thresh(thresh), .irq(irq)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish within 1ms");
      $fatal(1);
   end

   // Optionally fires a classifier event on the same edge as the write handshake.
   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic ev, input logic [7:0] ec);
      int n;
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (S_AXI_AWREADY !== 1'b1 && n < 20);
      if (S_AXI_AWREADY !== 1'b1) begin
         n_total++; $display("FAIL wr_awready_timeout addr=%h: got %b want 1", a, S_AXI_AWREADY);
      end
      if (ev) begin gesture_valid = 1'b1; gesture_code = ec; end
      @(negedge ACLK);
      gesture_valid = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n = 0;
      while (S_AXI_BVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
      if (S_AXI_BVALID !== 1'b1) begin
         n_total++; $display("FAIL wr_bvalid_timeout addr=%h: got %b want 1", a, S_AXI_BVALID);
      end
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] a, input logic ev, input logic [7:0] ec,
                           output logic [31:0] d, output logic [1:0] r);
      int n;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (S_AXI_ARREADY !== 1'b1 && n < 20);
      if (S_AXI_ARREADY !== 1'b1) begin
         n_total++; $display("FAIL rd_arready_timeout addr=%h: got %b want 1", a, S_AXI_ARREADY);
      end
      if (ev) begin gesture_valid = 1'b1; gesture_code = ec; end
      @(negedge ACLK);
      gesture_valid = 1'b0; S_AXI_ARVALID = 1'b0;
      n = 0;
      while (S_AXI_RVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
      if (S_AXI_RVALID !== 1'b1) begin
         n_total++; $display("FAIL rd_rvalid_timeout addr=%h: got %b want 1", a, S_AXI_RVALID);
      end
      d = S_AXI_RDATA; r = S_AXI_RRESP;
      @(negedge ACLK);
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] c);
      gesture_valid = 1'b1; gesture_code = c;
      @(negedge ACLK);
      gesture_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [3:0]  addrs [4];
      addrs[0] = 4'h0; addrs[1] = 4'h4; addrs[2] = 4'h8; addrs[3] = 4'hC;
      ARESETN = 1'b0;
      repeat (3) @(negedge ACLK);
      n_total++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0)
         $display("FAIL reset_handshake: got %b want 00000",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
      else n_pass++;
      n_total++;
      if ({S_AXI_RDATA, thresh, ctrl_enable, irq} !== 66'h0)
         $display("FAIL reset_outputs: rdata=%h thresh=%h en=%b irq=%b want all 0",
                  S_AXI_RDATA, thresh, ctrl_enable, irq);
      else n_pass++;
      ARESETN = 1'b1;
      @(negedge ACLK);
      for (int i = 0; i < 4; i++) begin
         axi_read(addrs[i], 1'b0, 8'h0, rd, rr);
         n_total++;
         if ({rd, rr} !== 34'h0)
            $display("FAIL reset_read addr=%h: got data=%h resp=%b want 00000000/00", addrs[i], rd, rr);
         else n_pass++;
      end
   endtask

   task automatic test_partial_handshake;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
      repeat (4) @(negedge ACLK);
      n_total++;
      if ({S_AXI_AWREADY, S_AXI_BVALID} !== 2'b00)
         $display("FAIL aw_only: got awready/bvalid=%b want 00", {S_AXI_AWREADY, S_AXI_BVALID});
      else n_pass++;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b1;
      repeat (4) @(negedge ACLK);
      n_total++;
      if ({S_AXI_WREADY, S_AXI_BVALID} !== 2'b00)
         $display("FAIL w_only: got wready/bvalid=%b want 00", {S_AXI_WREADY, S_AXI_BVALID});
      else n_pass++;
      S_AXI_WVALID = 1'b0;
      @(negedge ACLK);
   endtask

   task automatic test_wstrb;
      logic [31:0] rd;
      logic [1:0]  rr;
      int n;
      S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'b0011;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      n = 0;
      do begin @(negedge ACLK); n++; end while (S_AXI_AWREADY !== 1'b1 && n < 20);
      n_total++;
      if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11)
         $display("FAIL wstrb_ready: got %b want 11", {S_AXI_AWREADY, S_AXI_WREADY});
      else n_pass++;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n_total++;
      if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00)
         $display("FAIL wstrb_ready_one_cycle: got %b want 00", {S_AXI_AWREADY, S_AXI_WREADY});
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100)
            $display("FAIL bvalid_hold cycle %0d: got bvalid/bresp=%b want 100", i, {S_AXI_BVALID, S_AXI_BRESP});
         else n_pass++;
         @(negedge ACLK);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      n_total++;
      if (S_AXI_BVALID !== 1'b0)
         $display("FAIL bvalid_one_beat: got %b want 0", S_AXI_BVALID);
      else n_pass++;
      n_total++;
      if (thresh !== 32'h0000A5A5) $display("FAIL thresh_out: got %h want 0000a5a5", thresh);
      else n_pass++;
      axi_read(4'h4, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h0000A5A5) $display("FAIL thresh_read: got %h want 0000a5a5", rd);
      else n_pass++;
   endtask

   task automatic test_event;
      logic [31:0] rd;
      logic [1:0]  rr;
      axi_write(4'h0, 32'h3, 4'hF, 1'b0, 8'h0);
      n_total++;
      if ({ctrl_enable, irq} !== 2'b10) $display("FAIL ctrl_en: got en/irq=%b want 10", {ctrl_enable, irq});
      else n_pass++;
      pulse(8'h07);
      n_total++;
      if (irq !== 1'b1) $display("FAIL event_irq: got %b want 1", irq);
      else n_pass++;
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h80000107) $display("FAIL gesture_first: got %h want 80000107", rd);
      else n_pass++;
      axi_read(4'hC, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h1) $display("FAIL status_pend: got %h want 00000001", rd);
      else n_pass++;
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h00000107) $display("FAIL gesture_read_clear: got %h want 00000107", rd);
      else n_pass++;
   endtask

   task automatic test_overrun;
      logic [31:0] rd;
      logic [1:0]  rr;
      pulse(8'h09);
      axi_read(4'hC, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h3) $display("FAIL overrun_set: got %h want 00000003", rd);
      else n_pass++;
      axi_write(4'hC, 32'h1, 4'hF, 1'b1, 8'h0B);
      axi_read(4'hC, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h3) $display("FAIL w1c_pend_vs_event: got %h want 00000003", rd);
      else n_pass++;
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h8000030B) $display("FAIL gesture_count3: got %h want 8000030b", rd);
      else n_pass++;
      axi_write(4'hC, 32'h1, 4'hF, 1'b0, 8'h0);
      n_total++;
      if (irq !== 1'b0) $display("FAIL w1c_irq_fall: got %b want 0", irq);
      else n_pass++;
      axi_read(4'hC, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h2) $display("FAIL w1c_pend_only: got %h want 00000002", rd);
      else n_pass++;
      axi_write(4'hC, 32'h2, 4'hF, 1'b1, 8'h0D);
      axi_read(4'hC, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h1) $display("FAIL w1c_ovr_vs_event: got %h want 00000001", rd);
      else n_pass++;
      n_total++;
      if (irq !== 1'b1) $display("FAIL irq_reassert: got %b want 1", irq);
      else n_pass++;
   endtask

   task automatic test_read_event;
      logic [31:0] rd;
      logic [1:0]  rr;
      axi_read(4'h8, 1'b1, 8'h0C, rd, rr);
      n_total++;
      if (rd !== 32'h8000040D) $display("FAIL read_vs_event_data: got %h want 8000040d", rd);
      else n_pass++;
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h8000050C) $display("FAIL read_vs_event_valid: got %h want 8000050c", rd);
      else n_pass++;
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h0000050C) $display("FAIL read_clear_again: got %h want 0000050c", rd);
      else n_pass++;
      axi_read(4'hC, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h3) $display("FAIL status_after_read_event: got %h want 00000003", rd);
      else n_pass++;
   endtask

   task automatic test_disable;
      logic [31:0] rd;
      logic [1:0]  rr;
      axi_write(4'h0, 32'h0, 4'hF, 1'b0, 8'h0);
      n_total++;
      if ({ctrl_enable, irq} !== 2'b00) $display("FAIL disable_out: got en/irq=%b want 00", {ctrl_enable, irq});
      else n_pass++;
      pulse(8'h55);
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h0000050C) $display("FAIL disabled_event_dropped: got %h want 0000050c", rd);
      else n_pass++;
      axi_write(4'h8, 32'hFFFFFFFF, 4'hF, 1'b0, 8'h0);
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h0000050C) $display("FAIL gesture_ro: got %h want 0000050c", rd);
      else n_pass++;
      axi_write(4'h0, 32'hDEADBEEC, 4'hF, 1'b0, 8'h0);
      axi_read(4'h0, 1'b0, 8'h0, rd, rr);
      n_total++;
      if ({rd, ctrl_enable, irq} !== {32'hDEADBEEC, 2'b00})
         $display("FAIL ctrl_scratch: got %h en/irq=%b want deadbeec/00", rd, {ctrl_enable, irq});
      else n_pass++;
   endtask

   task automatic test_wrap;
      logic [31:0] rd;
      logic [1:0]  rr;
      ARESETN = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      axi_write(4'h0, 32'h1, 4'hF, 1'b0, 8'h0);
      gesture_valid = 1'b1; gesture_code = 8'h3C;
      repeat (255) @(negedge ACLK);
      gesture_valid = 1'b0;
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h8000FF3C) $display("FAIL count_255: got %h want 8000ff3c", rd);
      else n_pass++;
      pulse(8'h3C);
      axi_read(4'h8, 1'b0, 8'h0, rd, rr);
      n_total++;
      if (rd !== 32'h8000003C) $display("FAIL count_wrap: got %h want 8000003c", rd);
      else n_pass++;
      n_total++;
      if (irq !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [3:0]  addrs [4];
      int n;
      addrs[0] = 4'h0; addrs[1] = 4'h4; addrs[2] = 4'h8; addrs[3] = 4'hC;
      axi_write(4'h0, 32'h3, 4'hF, 1'b0, 8'h0);
      S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'hC;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      n = 0;
      do begin @(negedge ACLK); n++; end while (S_AXI_AWREADY !== 1'b1 && n < 20);
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      n_total++;
      if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, thresh, irq} !== {2'b11, 32'h3, 32'hCAFEF00D, 1'b1})
         $display("FAIL pre_reset: got b/r=%b rdata=%h thresh=%h irq=%b want 11/00000003/cafef00d/1",
                  {S_AXI_BVALID, S_AXI_RVALID}, S_AXI_RDATA, thresh, irq);
      else n_pass++;
      ARESETN = 1'b0;
      @(negedge ACLK);
      n_total++;
      if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, thresh, ctrl_enable, irq} !== 68'h0)
         $display("FAIL mid_reset: got b/r=%b rdata=%h thresh=%h en=%b irq=%b want all 0",
                  {S_AXI_BVALID, S_AXI_RVALID}, S_AXI_RDATA, thresh, ctrl_enable, irq);
      else n_pass++;
      ARESETN = 1'b1;
      @(negedge ACLK);
      for (int i = 0; i < 4; i++) begin
         axi_read(addrs[i], 1'b0, 8'h0, rd, rr);
         n_total++;
         if (rd !== 32'h0) $display("FAIL post_reset_read addr=%h: got %h want 00000000", addrs[i], rd);
         else n_pass++;
      end
      axi_write(4'h4, 32'h12345678, 4'hF, 1'b0, 8'h0);
      axi_read(4'h4, 1'b0, 8'h0, rd, rr);
      n_total++;
      if ({rd, thresh} !== {32'h12345678, 32'h12345678})
         $display("FAIL fresh_write: got read=%h thresh=%h want 12345678", rd, thresh);
      else n_pass++;
   endtask

   initial begin
      ARESETN = 1'b0;
      S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
      S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0; gesture_valid = 1'b0; gesture_code = 8'h0;
      test_reset();
      test_partial_handshake();
      test_wstrb();
      test_event();
      test_overrun();
      test_read_event();
      test_disable();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
